// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, falling-edge start detect,
// mid-bit sampling from a free-running baud counter, valid/framing-error strobes.
module uart_rx #(
  parameter int FPGA_FREQ = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int BAUD_END  = FPGA_FREQ / BAUD_RATE,
  parameter int BAUD_MID  = BAUD_END / 2 - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  // state | meaning
  // IDLE  | waiting for a 1->0 edge on the synchronized line
  // START | timing the start bit; mid-bit high means a glitch
  // DATA  | sampling eight data bits, LSB first
  // STOP  | sampling the stop bit, then strobe valid or framing error
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [12:0] END_M1 = 13'(BAUD_END - 1);
  localparam logic [12:0] MID    = 13'(BAUD_MID);

  state_t      state, state_nxt;
  logic [12:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, err_nxt;
  logic        rx_meta, rx_sync, rx_prev;
  logic        fall, at_mid, at_end;

  // Synchronizer flops reset high so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall   = rx_prev & ~rx_sync;
  assign at_mid = (baud_cnt == MID);
  assign at_end = (baud_cnt == END_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      baud_cnt     <= baud_nxt;
      bit_cnt      <= bit_nxt;
      shift        <= shift_nxt;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = at_end ? 13'd0 : baud_cnt + 13'd1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (at_mid && rx_sync) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
        end else if (at_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (at_mid) shift_nxt[bit_cnt] = rx_sync;
        if (at_end) begin
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so the next start edge is never missed.
        if (at_mid) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
          if (rx_sync) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames: it oversamples the `rx` line with a free-running baud counter and samples each bit at its midpoint. It delivers each received byte as a one-cycle `rx_valid` strobe and flags bad stop bits. It is the receive-side counterpart of the design's UART transmitter and shares its baud constants, so host-to-FPGA command/data traffic (e.g. SDRAM test patterns) enters the design here.

## Interface
- `FPGA_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `BAUD_END`, default `FPGA_FREQ/BAUD_RATE` (5208): clocks per bit.
  - Compute with integer division of the frequency by the rate.
  - Simulation overrides it to 56.
  - Legal range 4..8192.
- `BAUD_MID`, default `BAUD_END/2 - 1` (2603; 27 in sim): in-bit sample point.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input, idle high.
- `rx_data` out 8: last correctly framed byte, LSB received first.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new in that same cycle.
- `rx_frame_err` out 1: one-cycle strobe; stop bit sampled low, byte discarded.
- `rx_busy` out 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops into `rx_sync`; a third flop gives `rx_prev`.
  - All three flops reset to 1, so reset never produces a false edge.
  - Falling edge = `rx_prev & ~rx_sync`.
- **States:** IDLE, START, DATA, STOP.
  - 13-bit `baud_cnt`: held at 0 in IDLE; otherwise counts 0..`BAUD_END`-1 and wraps.
  - 3-bit `bit_cnt`.
  - 8-bit shift register.
- **IDLE:** on a falling edge, go to START with `baud_cnt`=0. Edges seen in any other state are ignored.
- **START:** at `baud_cnt`==`BAUD_MID`, if `rx_sync`==1 this is a glitch: return to IDLE with no strobe. Otherwise, at `baud_cnt`==`BAUD_END`-1, go to DATA with `bit_cnt`=0.
- **DATA:** at `BAUD_MID`, write `rx_sync` into shift bit `bit_cnt` (LSB first). At `BAUD_END`-1:
  - if `bit_cnt`==7, go to STOP;
  - else increment `bit_cnt`.
- **STOP:** at `BAUD_MID`, go to IDLE immediately. This leaves half a bit of margin, so back-to-back frames are received.
  - `rx_sync`==1: load `rx_data` from the shift register and pulse `rx_valid`.
  - `rx_sync`==0: pulse `rx_frame_err`; `rx_data` is unchanged.
- **After a framing error:** the line may still be low (break). The receiver re-arms only on a fresh 1→0 edge, so a held-low line yields exactly one error and no further frames.
- **Sticky outputs:** `rx_data` keeps its value until the next good frame.
- **Strobe exclusivity:** `rx_valid` and `rx_frame_err` are never high in the same cycle.

## Timing
- **Reset values:**
  - `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0.
  - State IDLE; all counters 0.
  - Synchronizer flops = 1.
- **Reset mid-frame:** `rst` high in any cycle aborts the frame at the next edge. No strobe is emitted, and the partial byte is dropped.
- **Edge detection:** a pin falling between edges P-1 and P is seen as `rx_sync`=0 after edge P+1. Detection happens in cycle E = P+1.
  - START with `baud_cnt`=0 holds from E+1.
  - `rx_busy` rises at E+1.
- **Sample times (offsets from E+1):**
  - Bit k (0 = start, 1..8 = data, 9 = stop) is sampled at offset k·`BAUD_END`+`BAUD_MID`.
  - `rx_valid`/`rx_frame_err` go high at E+2+9·`BAUD_END`+`BAUD_MID` for exactly 1 cycle.
  - `rx_busy` falls in the same cycle.
- **Glitch:** a low pulse shorter than about `BAUD_MID` clocks returns to IDLE at E+2+`BAUD_MID`.
- **Rate tolerance:** ±4% baud mismatch is tolerated by mid-bit sampling. There is no majority vote.

## Test plan
All scenarios use `BAUD_END`=56 and `BAUD_MID`=27.

1. **Reset:** assert `rst` for 3 cycles with `rx`=1.
   - Outputs 0, `rx_busy`=0.
   - No strobes for 1000 idle cycles.
2. **Single byte:** send 8'hA5 at 56 clk/bit.
   - Exactly one `rx_valid` pulse, at E+2+9·56+27.
   - `rx_data`=8'hA5 and remains so afterwards.
   - `rx_frame_err` never asserts.
3. **Back-to-back:** send 8'h00, 8'hFF, 8'h3C with no idle gap.
   - Three `rx_valid` pulses spaced 560 cycles apart.
   - `rx_data` is 8'h00, 8'hFF, 8'h3C in order.
4. **Framing error:** send 8'h5A with the stop bit driven low, then hold `rx` low for 2000 cycles.
   - One `rx_frame_err` pulse, no `rx_valid`, `rx_data` unchanged.
   - After `rx` returns high, sending 8'h81 yields a valid 8'h81.
5. **Glitch:** apply a 10-cycle low pulse on idle `rx`.
   - `rx_busy` pulses high, then the block returns to IDLE.
   - No strobes.
   - A following 8'hC3 frame is received correctly.
6. **Reset mid-frame:** assert `rst` for one cycle during data bit 4 of 8'h96.
   - No strobe; `rx_data`=0.
   - The next 8'h96 frame is received correctly.
